// File: rtl/tdc_therm_readout_if.sv
// tdc_therm_readout_if
// Groups the TDC readout's control/result signals into one bundle.
//   master : drives term/arm/clear, observes results (test logic, pin mux)
//   slave  : the readout block itself
// Ports carried:
//   term[7:0]   asynchronous thermometer code from the delay line
//   arm, clear  synchronous measurement start / abort
//   busy, code_valid, code[3:0], bubble_err, avg_valid, avg[3:0], timeout
interface tdc_therm_readout_if;
  logic [7:0] term;
  logic       arm;
  logic       clear;
  logic       busy;
  logic       code_valid;
  logic [3:0] code;
  logic       bubble_err;
  logic       avg_valid;
  logic [3:0] avg;
  logic       timeout;

  modport master (
    output term, arm, clear,
    input  busy, code_valid, code, bubble_err, avg_valid, avg, timeout
  );

  modport slave (
    input  term, arm, clear,
    output busy, code_valid, code, bubble_err, avg_valid, avg, timeout
  );
endinterface

// File: rtl/tdc_therm_readout.sv
// tdc_therm_readout
// Synchronizes the vernier TDC thermometer code into clk, waits for a full
// start/stop event, lets the code settle, captures and encodes it to a
// popcount with bubble detection, and averages 2^LOG2_AVG captures.
// Ports:
//   clk    single clock
//   rst_n  asynchronous active-low reset
//   bus    tdc_therm_readout_if.slave (term/arm/clear in, results out)
//
// state      | meaning
// -----------+-----------------------------------------------------------
// S_IDLE     | waiting for arm
// S_WAIT_ZRO | waiting for the TDC to re-initialize (synchronized code 0)
// S_ARMED    | waiting for the first nonzero synchronized code
// S_SETTLE   | letting the code settle; captures on the last cycle
// S_DONE     | code_valid (and possibly avg_valid) pulse cycle
// S_TOUT     | timeout pulse cycle
module tdc_therm_readout #(
  parameter int SYNC_STAGES    = 2,
  parameter int SETTLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int LOG2_AVG       = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  tdc_therm_readout_if.slave  bus
);

  localparam int NAVG = 1 << LOG2_AVG;
  localparam int SW   = 4 + LOG2_AVG;
  localparam int NW   = (LOG2_AVG > 0) ? LOG2_AVG : 1;
  localparam int SCW  = $clog2(SETTLE_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_ZRO, S_ARMED, S_SETTLE, S_DONE, S_TOUT
  } state_t;

  state_t                            state;
  logic [SYNC_STAGES-1:0][7:0]       sync_q;
  logic [7:0]                        ts;
  logic [SCW-1:0]                    settle_cnt;
  logic [15:0]                       tout_cnt;
  logic [SW-1:0]                     acc;
  logic [NW-1:0]                     smp_cnt;
  logic                              busy_q, code_valid_q, bubble_q, avg_valid_q, timeout_q;
  logic [3:0]                        code_q, avg_q;

  logic [3:0]                        ts_ones;
  logic                              ts_bubble;
  logic [SW-1:0]                     sum_next;
  logic                              last_sample;

  function automatic logic [3:0] ones8(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) n = n + {3'b000, v[i]};
    return n;
  endfunction

  // Synchronizer is deliberately untouched by clear; only reset empties it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], bus.term};
  end

  assign ts = sync_q[SYNC_STAGES-1];

  // A valid thermometer code plus one is a power of two, so the AND is zero;
  // 8'hFF wraps to zero and is therefore legal.
  assign ts_ones     = ones8(ts);
  assign ts_bubble   = |(ts & (ts + 8'd1));
  assign sum_next    = acc + SW'(ts_ones);
  assign last_sample = (smp_cnt == NW'(NAVG - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      settle_cnt   <= '0;
      tout_cnt     <= '0;
      acc          <= '0;
      smp_cnt      <= '0;
      busy_q       <= 1'b0;
      code_valid_q <= 1'b0;
      code_q       <= '0;
      bubble_q     <= 1'b0;
      avg_valid_q  <= 1'b0;
      avg_q        <= '0;
      timeout_q    <= 1'b0;
    end else begin
      code_valid_q <= 1'b0;
      avg_valid_q  <= 1'b0;
      timeout_q    <= 1'b0;
      if (bus.clear) begin
        state      <= S_IDLE;
        busy_q     <= 1'b0;
        settle_cnt <= '0;
        tout_cnt   <= '0;
        acc        <= '0;
        smp_cnt    <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (bus.arm) begin
              state    <= S_WAIT_ZRO;
              busy_q   <= 1'b1;
              tout_cnt <= 16'(TIMEOUT_CYCLES);
            end
          end
          S_WAIT_ZRO: begin
            if (tout_cnt == 16'd1) begin
              state     <= S_TOUT;
              timeout_q <= 1'b1;
            end else begin
              tout_cnt <= tout_cnt - 16'd1;
              if (ts == 8'd0) state <= S_ARMED;
            end
          end
          S_ARMED: begin
            // Timeout wins if the first nonzero code lands on the final count.
            if (tout_cnt == 16'd1) begin
              state     <= S_TOUT;
              timeout_q <= 1'b1;
            end else begin
              tout_cnt <= tout_cnt - 16'd1;
              if (ts != 8'd0) begin
                state      <= S_SETTLE;
                settle_cnt <= SCW'(SETTLE_CYCLES);
              end
            end
          end
          S_SETTLE: begin
            if (settle_cnt == SCW'(1)) begin
              // Encoding happens at the capture edge so the results are
              // already registered during the DONE cycle.
              state        <= S_DONE;
              code_valid_q <= 1'b1;
              code_q       <= ts_ones;
              bubble_q     <= ts_bubble;
              if (last_sample) begin
                avg_valid_q <= 1'b1;
                avg_q       <= 4'(sum_next >> LOG2_AVG);
                acc         <= '0;
                smp_cnt     <= '0;
              end else begin
                acc     <= sum_next;
                smp_cnt <= smp_cnt + NW'(1);
              end
            end else begin
              settle_cnt <= settle_cnt - SCW'(1);
            end
          end
          S_DONE, S_TOUT: begin
            state  <= S_IDLE;
            busy_q <= 1'b0;
          end
          default: begin
            state  <= S_IDLE;
            busy_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.busy       = busy_q;
  assign bus.code_valid = code_valid_q;
  assign bus.code       = code_q;
  assign bus.bubble_err = bubble_q;
  assign bus.avg_valid  = avg_valid_q;
  assign bus.avg        = avg_q;
  assign bus.timeout    = timeout_q;

endmodule

// File: tb/tb_tdc_therm_readout.sv
module tb_tdc_therm_readout;
  localparam int SYNC   = 2;
  localparam int SETTLE = 4;
  localparam int TOUT   = 20;
  localparam int L2     = 2;
  localparam int NAVG   = 1 << L2;
  localparam int WIN    = 30;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  tdc_therm_readout_if bus();

  tdc_therm_readout #(
    .SYNC_STAGES(SYNC), .SETTLE_CYCLES(SETTLE),
    .TIMEOUT_CYCLES(TOUT), .LOG2_AVG(L2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Reference state: codes accumulated since the last clear/reset, and the
  // values the held outputs should currently show.
  int q[$];
  int held_code = 0, held_bub = 0, held_avg = 0;

  typedef struct {
    logic [7:0] pre;
    int         n_zero;
    logic [7:0] val;
    int         clr_at;
    int         kind;   // 1 capture, 2 timeout
    int         code;
    int         bub;
    int         avg;    // -1: no avg_valid expected
  } vec_t;

  vec_t tab[22];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int pop8(input logic [7:0] v);
    return int'($countones(v));
  endfunction

  function automatic int is_bubble(input logic [7:0] v);
    logic [7:0] legal;
    legal = 8'hFF >> (8 - pop8(v));
    return (v != legal) ? 1 : 0;
  endfunction

  function automatic int outs_word();
    return {bus.busy, bus.code_valid, bus.code, bus.bubble_err,
            bus.avg_valid, bus.avg, bus.timeout};
  endfunction

  // One measurement: term held at pre, arm, then term=val driven n_zero
  // cycles after the arm cycle (pre!=0 keeps term stuck). Optional clear
  // clr_at cycles after arm. Timing derived from the documented latencies.
  task automatic meas(input logic [7:0] pre, input int n_zero, input logic [7:0] val,
                      input int clr_at, input int use_tab, input int t_kind,
                      input int t_code, input int t_bub, input int t_avg);
    int t, e_cyc, kind, ecode, ebub, eavg_v, eavg, supp, fall, s;
    int n_cv, n_to, n_av, cv_cyc, to_cyc, gcode, gbub, gavg, busy_fall, busy1;
    n_cv = 0; n_to = 0; n_av = 0; cv_cyc = -1; to_cyc = -1;
    gcode = 0; gbub = 0; gavg = 0; busy_fall = -1; busy1 = 0;

    @(negedge clk);
    bus.term = pre;
    repeat (3) @(negedge clk);
    t = cyc;
    bus.arm = 1'b1;
    if (pre == 8'd0 && n_zero == 0) bus.term = val;

    if (pre != 8'd0 || val == 8'd0 || n_zero + SYNC >= TOUT) begin
      kind = 2; e_cyc = t + TOUT + 1;
    end else begin
      kind = 1; e_cyc = t + n_zero + SYNC + SETTLE + 1;
    end
    ecode = pop8(val);
    ebub  = is_bubble(val);
    if (use_tab != 0) begin
      kind = t_kind; ecode = t_code; ebub = t_bub;
    end
    supp = (clr_at > 0 && t + clr_at < e_cyc) ? 1 : 0;
    fall = (supp != 0) ? t + clr_at + 1 : e_cyc + 1;

    eavg_v = 0; eavg = 0;
    if (supp == 0 && kind == 1) begin
      q.push_back(ecode);
      if (q.size() == NAVG) begin
        s = 0;
        foreach (q[k]) s += q[k];
        eavg_v = 1; eavg = s / NAVG;
        q.delete();
      end
    end
    if (clr_at > 0) q.delete();
    if (use_tab != 0) begin
      eavg_v = (t_avg >= 0) ? 1 : 0;
      eavg   = t_avg;
    end

    for (int i = 1; i <= WIN; i++) begin
      @(negedge clk);
      if (i == 1) busy1 = bus.busy;
      if (bus.code_valid) begin
        n_cv++; cv_cyc = cyc; gcode = bus.code; gbub = bus.bubble_err;
      end
      if (bus.avg_valid) begin
        n_av++; gavg = bus.avg;
      end
      if (bus.timeout) begin
        n_to++; to_cyc = cyc;
      end
      if (!bus.busy && busy_fall < 0) busy_fall = cyc;
      bus.arm = 1'b0;
      if (pre == 8'd0 && i == n_zero) bus.term = val;
      bus.clear = (i == clr_at);
    end
    bus.clear = 1'b0;
    bus.term  = 8'd0;

    chk("busy_rise", busy1, 1);
    chk("busy_fall_cycle", busy_fall, fall);
    if (supp != 0) begin
      chk("supp_code_valid", n_cv, 0);
      chk("supp_timeout", n_to, 0);
      chk("supp_avg_valid", n_av, 0);
    end else if (kind == 1) begin
      chk("code_valid_count", n_cv, 1);
      chk("code_valid_cycle", cv_cyc, e_cyc);
      chk("code", gcode, ecode);
      chk("bubble_err", gbub, ebub);
      chk("no_timeout", n_to, 0);
      chk("avg_valid_count", n_av, eavg_v);
      if (eavg_v != 0) chk("avg", gavg, eavg);
      held_code = ecode; held_bub = ebub;
      if (eavg_v != 0) held_avg = eavg;
    end else begin
      chk("timeout_count", n_to, 1);
      chk("timeout_cycle", to_cyc, e_cyc);
      chk("timeout_no_code", n_cv, 0);
      chk("timeout_no_avg", n_av, 0);
    end
    chk("held_code", bus.code, held_code);
    chk("held_bubble", bus.bubble_err, held_bub);
    chk("held_avg", bus.avg, held_avg);
  endtask

  initial begin
    int t, busy_at[16], cv_at;
    logic [7:0] v;
    int nz, ca;

    tab[0]  = '{8'h00,  5, 8'h1F, 0, 1, 5, 0, -1};
    tab[1]  = '{8'h00,  2, 8'h17, 0, 1, 4, 1, -1};
    tab[2]  = '{8'h00,  0, 8'hFF, 0, 1, 8, 0, -1};
    tab[3]  = '{8'h00,  3, 8'h03, 0, 1, 2, 0,  4};
    tab[4]  = '{8'h00,  1, 8'h03, 0, 1, 2, 0, -1};
    tab[5]  = '{8'h00,  4, 8'h07, 0, 1, 3, 0, -1};
    tab[6]  = '{8'h00,  6, 8'h07, 0, 1, 3, 0, -1};
    tab[7]  = '{8'h00,  2, 8'h1F, 0, 1, 5, 0,  3};
    tab[8]  = '{8'h00,  0, 8'hFF, 0, 1, 8, 0, -1};
    tab[9]  = '{8'h00,  3, 8'hFF, 0, 1, 8, 0, -1};
    tab[10] = '{8'h00,  9, 8'hFF, 0, 1, 8, 0, -1};
    tab[11] = '{8'h00, 17, 8'hFF, 0, 1, 8, 0,  8};
    tab[12] = '{8'hFF,  0, 8'hFF, 0, 2, 0, 0, -1};
    tab[13] = '{8'h00,  0, 8'h00, 0, 2, 0, 0, -1};
    tab[14] = '{8'h00, 18, 8'hFF, 0, 2, 0, 0, -1};
    tab[15] = '{8'h00,  1, 8'h0F, 0, 1, 4, 0, -1};
    tab[16] = '{8'h00,  2, 8'h0F, 0, 1, 4, 0, -1};
    tab[17] = '{8'h00,  1, 8'h0F, 5, 1, 4, 0, -1};
    tab[18] = '{8'h00,  0, 8'h0F, 0, 1, 4, 0, -1};
    tab[19] = '{8'h00,  3, 8'h0F, 0, 1, 4, 0, -1};
    tab[20] = '{8'h00,  7, 8'h0F, 0, 1, 4, 0, -1};
    tab[21] = '{8'h00,  2, 8'h0F, 0, 1, 4, 0,  4};

    bus.term = 8'd0; bus.arm = 1'b0; bus.clear = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", outs_word(), 0);
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("post_reset_idle", outs_word(), 0);
    end

    foreach (tab[i])
      meas(tab[i].pre, tab[i].n_zero, tab[i].val, tab[i].clr_at, 1,
           tab[i].kind, tab[i].code, tab[i].bub, tab[i].avg);

    // arm held high through DONE: ignored in DONE, accepted in following IDLE
    @(negedge clk);
    repeat (3) @(negedge clk);
    t = cyc;
    bus.arm = 1'b1;
    bus.term = 8'h3F;
    cv_at = -1;
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      busy_at[i] = bus.busy;
      if (bus.code_valid && cv_at < 0) cv_at = cyc;
      if (i == 9) begin
        bus.arm = 1'b0;
        bus.clear = 1'b1;
      end
    end
    @(negedge clk);
    bus.clear = 1'b0;
    bus.term = 8'd0;
    chk("b2b_code_valid_cycle", cv_at, t + SYNC + SETTLE + 1);
    chk("b2b_busy_in_done", busy_at[7], 1);
    chk("b2b_busy_after_done", busy_at[8], 0);
    chk("b2b_rearm_busy", busy_at[9], 1);
    chk("b2b_clear_busy", bus.busy, 0);
    q.delete();
    held_code = 6; held_bub = 0;
    chk("b2b_code", bus.code, 6);

    // arm together with clear in IDLE: clear wins
    repeat (3) @(negedge clk);
    bus.arm = 1'b1; bus.clear = 1'b1;
    @(negedge clk);
    bus.arm = 1'b0; bus.clear = 1'b0;
    chk("armclr_busy", bus.busy, 0);
    @(negedge clk);
    chk("armclr_busy_later", bus.busy, 0);

    // reset asserted mid-SETTLE
    repeat (3) @(negedge clk);
    t = cyc;
    bus.arm = 1'b1;
    bus.term = 8'h1F;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      bus.arm = 1'b0;
    end
    chk("pre_reset_busy", bus.busy, 1);
    rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", outs_word(), 0);
    @(negedge clk);
    bus.term = 8'd0;
    @(negedge clk);
    rst_n = 1'b1;
    q.delete();
    held_code = 0; held_bub = 0; held_avg = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("post_reset_quiet", outs_word(), 0);
    end

    // randomized measurements against the reference
    for (int r = 0; r < 40; r++) begin
      v  = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 7) == 0) v = 8'd0;
      else if ($urandom_range(0, 1) == 0) v = 8'hFF >> $urandom_range(0, 7);
      nz = $urandom_range(0, 20);
      ca = ($urandom_range(0, 4) == 0) ? $urandom_range(1, WIN) : 0;
      meas(8'h00, nz, v, ca, 0, 0, 0, 0, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
